multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Multi-cycle RV32I main controller. It replaces the single-cycle opcode decoder. A state machine sequences fetch, decode, execute, memory and writeback over several cycles, and drives a datapath built around a shared memory, IR, MDR and ALUOut. Adds a memory ready handshake with timeout, optional jump/upper-immediate/I-ALU support, and an illegal-opcode trap.

Parameters:
EXT_EN, 1, 1 = decode I-ALU (0010011), JAL, JALR, LUI, AUIPC; 0 = those opcodes trap
ALUOP_W, 2, width of alu_op (≥2; upper bits zero)
MEM_TIMEOUT, 16, max wait cycles for mem_ready before trapping (≥1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0], stable from DECODE until next FETCH
mem_ready  input  1  memory completes the current access this cycle
ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, reg_write  output  1 each  datapath strobes
alu_src_a  output  2  0=PC, 1=rs1, 2=old PC, 3=zero
alu_src_b  output  2  0=rs2, 1=imm, 2=const 4
alu_op  output  ALUOP_W  0=add, 1=sub/compare, 2=R funct, 3=I funct
pc_source  output  2  0=ALU result, 1=ALUOut, 2=ALU result & ~1
mem_to_reg  output  2  0=ALUOut, 1=MDR, 2=PC
illegal  output  1  sticky trap flag
state  output  4  current state encoding, for debug

Behaviour:
- Moore outputs, decoded from the registered state only. Any output not listed for a state is 0.
- rst_n low → state=RST(15), wait counter=0. All outputs 0, including illegal.
- RST → FETCH unconditionally on the first edge after release.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_b=2, pc_source=0.
  - ir_write=pc_write=mem_ready; these two are the only combinational dependence.
  - mem_ready=1 → DECODE; otherwise stay.
- DECODE(1): alu_src_a=2, alu_src_b=1 (target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - with EXT_EN=1: 0010011 → EXEC_I, 1101111 → JAL, 1100111 → JALR, 0110111 → LUI, 0010111 → AUIPC
  - anything else → TRAP
- MEM_ADDR(2): alu_src_a=1, alu_src_b=1. Next: MEM_READ for loads, MEM_WRITE for stores.
- MEM_READ(3): mem_read=1, i_or_d=1. Wait for mem_ready, then → MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1 → FETCH.
- MEM_WRITE(5): mem_write=1, i_or_d=1. Wait for mem_ready, then → FETCH.
- EXEC_R(6): alu_src_a=1, alu_op=2 → ALU_WB.
- ALU_WB(7): reg_write=1, mem_to_reg=0 → FETCH.
- BRANCH(8): alu_src_a=1, alu_op=1, pc_write_cond=1, pc_source=1 → FETCH.
- EXEC_I(9): alu_src_a=1, alu_src_b=1, alu_op=3 → ALU_WB.
- JAL(10): pc_write=1, pc_source=1, reg_write=1, mem_to_reg=2 → FETCH.
- JALR(11): alu_src_a=1, alu_src_b=1, pc_write=1, pc_source=2, reg_write=1, mem_to_reg=2 → FETCH.
- LUI(12): alu_src_a=3, alu_src_b=1 → ALU_WB.
- AUIPC(13): alu_src_a=2, alu_src_b=1 → ALU_WB.
- TRAP(14): illegal=1, all strobes 0. Held until reset.
- Wait counter:
  - cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - increments each cycle those states see mem_ready=0.
  - reaching MEM_TIMEOUT with mem_ready=0 → TRAP on the next edge.
  - mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT → normal transition (ready wins).
  - width $clog2(MEM_TIMEOUT+1); no wrap.
- Encodings 15 is RST; any unreachable encoding → FETCH.
- Reset mid-access: outputs drop to 0 asynchronously and no strobe completes.
- Per-instruction cycle counts at mem_ready=1:
  - R/I/LUI/AUIPC: 4
  - load: 5
  - store: 4
  - branch, JAL, JALR: 3

Test Plan:
- Reset, opcode=0110011, mem_ready=1 → state 15,0,1,6,7,0. reg_write high only in state 7; ir_write one pulse.
- opcode=0000011, mem_ready low 3 cycles in MEM_READ → state 3 held 4 cycles, mem_read=i_or_d=1 throughout, then 4 (reg_write, mem_to_reg=1), then 0.
- opcode=1100011 → BRANCH cycle shows pc_write_cond=1, pc_source=1, alu_op=1, pc_write=0.
- EXT_EN=1, opcode=1100111 → JALR: pc_source=2, mem_to_reg=2, pc_write=reg_write=1. EXT_EN=0, same opcode → TRAP, illegal=1 held until rst_n.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH → TRAP after 5 cycles in FETCH. Repeat with mem_ready=1 on the 5th cycle → DECODE, no trap.
- rst_n low during MEM_WRITE → mem_write=0 immediately, state=15; after release, fetch restarts at state 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I main controller. It steps each instruction through fetch, decode,
// execute, memory and writeback, waits on mem_ready with a timeout, and traps illegal opcodes.
module multicycle_control_unit #(
  parameter int EXT_EN      = 1,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic [1:0]         mem_to_reg,
  output logic               illegal,
  output logic [3:0]         state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_EXEC_I    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_TRAP      = 4'd14,
    S_RST       = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          wait_st;
  logic          timed_out;
  logic          ext_on;

  assign ext_on    = (EXT_EN != 0);
  assign wait_st   = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timed_out = (wait_cnt_q == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timed_out) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_IALU:           state_d = ext_on ? S_EXEC_I : S_TRAP;
          OP_JAL:            state_d = ext_on ? S_JAL    : S_TRAP;
          OP_JALR:           state_d = ext_on ? S_JALR   : S_TRAP;
          OP_LUI:            state_d = ext_on ? S_LUI    : S_TRAP;
          OP_AUIPC:          state_d = ext_on ? S_AUIPC  : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)      state_d = S_MEM_WB;
        else if (timed_out) state_d = S_TRAP;
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timed_out) state_d = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALU_WB;
      S_ALU_WB, S_BRANCH, S_JAL, S_JALR:  state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Any change of state restarts the count, so every entry into a wait state begins at zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (wait_st && !mem_ready && !timed_out)
      wait_cnt_d = wait_cnt_q + CW'(1);
  end

  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = '0;
    pc_source     = 2'd0;
    mem_to_reg    = 2'd0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd2;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'd1;
        alu_op    = ALUOP_W'(2);
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 2'd1;
        alu_op        = ALUOP_W'(1);
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        alu_op    = ALUOP_W'(3);
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'd1;
        reg_write  = 1'b1;
        mem_to_reg = 2'd2;
      end
      S_JALR: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd1;
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        reg_write  = 1'b1;
        mem_to_reg = 2'd2;
      end
      S_LUI: begin
        alu_src_a = 2'd3;
        alu_src_b = 2'd1;
      end
      S_AUIPC: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
